// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_e;

  localparam int START_BITS    = 1;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;
  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 8;
  localparam int BIT_IDX_W     = 3;

  function automatic bit data_bits_legal(int n);
    return (n >= MIN_DATA_BITS) && (n <= MAX_DATA_BITS);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period divider for the transmitter; counts 0..P-1 only while a frame runs.
module uart_tx_bit_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        run,
  input  logic [15:0] period,
  output logic        bit_end
);

  logic [15:0] count_q, count_d;
  logic [15:0] last_count;

  // A programmed period of zero behaves like a period of one.
  assign last_count = (period == 16'd0) ? 16'd0 : period - 16'd1;
  assign bit_end    = run & (count_q == last_count);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = (count_q == last_count) ? '0 : count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: handshake in, framed serial bits out, with a
// one-entry holding buffer so back-to-back frames leave no idle gap.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [15:0]          clk_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  if (!data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
    $error("uart_tx_ctrl: DATA_BITS must be within 5..8");
  end

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic [BIT_IDX_W-1:0]   idx_q, idx_d;
  logic                   par_bit_q, par_bit_d;
  logic                   par_en_q, par_en_d;
  logic                   two_stop_q, two_stop_d;
  logic [15:0]            div_q, div_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;

  logic                   hs;
  logic                   bit_end;
  logic                   frame_end;
  logic                   do_load;
  logic [DATA_BITS-1:0]   load_data;

  assign tx_ready   = en & ~buf_full_q;
  assign hs         = tx_valid & tx_ready;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

  uart_tx_bit_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (do_load),
    .run     (busy),
    .period  (div_q),
    .bit_end (bit_end)
  );

  // tx_d always carries the level of the state being entered, so the pin
  // comes straight from a flop. Frame starts (fresh or from the buffer) all
  // funnel through do_load, which also latches the per-frame configuration.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    idx_d      = idx_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    div_d      = div_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    frame_end  = 1'b0;
    do_load    = 1'b0;
    load_data  = tx_data;

    if (!en) begin
      state_d    = IDLE;
      tx_d       = 1'b1;
      buf_full_d = 1'b0;
    end else begin
      if (hs && (state_q != IDLE)) begin
        buf_d      = tx_data;
        buf_full_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (hs) do_load = 1'b1;
        end
        START: begin
          if (bit_end) begin
            state_d = DATA;
            idx_d   = '0;
            tx_d    = shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_d = shift_q >> 1;
            if (idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
              state_d = par_en_q ? PARITY : STOP1;
              tx_d    = par_en_q ? par_bit_q : 1'b1;
            end else begin
              idx_d = idx_q + BIT_IDX_W'(1);
              tx_d  = shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_d = STOP1;
            tx_d    = 1'b1;
          end
        end
        STOP1: begin
          if (bit_end) begin
            if (two_stop_q) begin
              state_d = STOP2;
              tx_d    = 1'b1;
            end else begin
              frame_end = 1'b1;
            end
          end
        end
        STOP2: begin
          if (bit_end) frame_end = 1'b1;
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase

      // A byte offered on the closing edge bypasses the empty buffer.
      if (frame_end) begin
        done_d = 1'b1;
        if (buf_full_q) begin
          do_load    = 1'b1;
          load_data  = buf_q;
          buf_full_d = 1'b0;
        end else if (hs) begin
          do_load    = 1'b1;
          buf_full_d = 1'b0;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end

      if (do_load) begin
        shift_d    = load_data;
        par_bit_d  = (^load_data) ^ parity_odd;
        par_en_d   = parity_en;
        two_stop_d = two_stop;
        div_d      = clk_div;
        idx_d      = '0;
        state_d    = START;
        tx_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      idx_q      <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      div_q      <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      idx_q      <= idx_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

endmodule
